// File: rtl/div_seq_ctrl.sv
// Multi-cycle radix-2 restoring DIV/DIVU sequencer sitting behind EX; one quotient bit per clock.
// Optional divide-by-zero flag output enabled by defining DIV_ZERO_FLAG_EN.
module div_seq_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic                div_zero_o
`endif
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  // dvd doubles as the quotient: dividend bits shift out the top, quotient bits shift in below
  typedef struct packed {
    logic [DATA_W-1:0] dvd;
    logic [DATA_W-1:0] dvs;
    logic [DATA_W-1:0] part;
    logic              neg_q;
    logic              neg_r;
  } op_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  op_t                 op, op_n;
  logic [2*DATA_W-1:0] result_q, result_n;
  logic                ready_q, ready_n;
`ifdef DIV_ZERO_FLAG_EN
  logic                dz_q, dz_n;
`endif

  logic              a_neg, b_neg;
  logic [DATA_W:0]   trial, diff;
  logic              ge;
  logic [DATA_W-1:0] quot_fix, rem_fix;

  // partial remainder kept one bit wider on the compare so divisors >= 2^(DATA_W-1) work
  assign a_neg    = signed_div_i & opdata1_i[DATA_W-1];
  assign b_neg    = signed_div_i & opdata2_i[DATA_W-1];
  assign trial    = {op.part, op.dvd[DATA_W-1]};
  assign ge       = (trial >= {1'b0, op.dvs});
  assign diff     = trial - {1'b0, op.dvs};
  assign quot_fix = op.neg_q ? (DATA_W'(0) - op.dvd)  : op.dvd;
  assign rem_fix  = op.neg_r ? (DATA_W'(0) - op.part) : op.part;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op       <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz_q     <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      op       <= op_n;
      result_q <= result_n;
      ready_q  <= ready_n;
`ifdef DIV_ZERO_FLAG_EN
      dz_q     <= dz_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    op_n     = op;
    result_n = result_q;
    ready_n  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
    dz_n     = dz_q;
`endif
    case (state)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_n = S_DIVZERO;
          end else begin
            state_n    = S_ON;
            cnt_n      = '0;
            op_n.dvd   = a_neg ? (DATA_W'(0) - opdata1_i) : opdata1_i;
            op_n.dvs   = b_neg ? (DATA_W'(0) - opdata2_i) : opdata2_i;
            op_n.part  = '0;
            op_n.neg_q = a_neg ^ b_neg;
            op_n.neg_r = a_neg;
          end
        end
      end
      S_DIVZERO: begin
        state_n  = S_END;
        result_n = '0;
        ready_n  = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
        dz_n     = 1'b1;
`endif
      end
      S_ON: begin
        if (annul_i) begin
          state_n  = S_IDLE;
          result_n = '0;
          ready_n  = 1'b0;
        end else if (cnt < CNT_W'(DATA_W)) begin
          op_n.part = ge ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
          op_n.dvd  = {op.dvd[DATA_W-2:0], ge};
          cnt_n     = cnt + CNT_W'(1);
        end else begin
          state_n  = S_END;
          result_n = {rem_fix, quot_fix};
          ready_n  = 1'b1;
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          state_n  = S_IDLE;
          result_n = '0;
          ready_n  = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
          dz_n     = 1'b0;
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  // low in END so EX can retire the instruction and drop start_i
  assign stallreq_o = start_i & ~annul_i & (state != S_END);
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero_o = dz_q;
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: directed table, annul/reset sequences and random divides vs a 64-bit arithmetic model.
module tb_div_seq_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sgn = 1'b0;
  logic         start = 1'b0;
  logic         annul = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [2*W-1:0] result;
  logic         ready, stall;
`ifdef DIV_ZERO_FLAG_EN
  logic         dz;
`endif

  int nvec = 0;
  int nmis = 0;

  div_seq_ctrl #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .signed_div_i(sgn), .opdata1_i(a), .opdata2_i(b),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready),
    .stallreq_o(stall)
`ifdef DIV_ZERO_FLAG_EN
    , .div_zero_o(dz)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
    end
  endtask

  // reference: plain 64-bit arithmetic, truncating division, results wrapped to 32 bits
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint xs, ys, q, r;
    if (y == 0) return 64'd0;
    if (s) begin
      xs = longint'($signed(x));
      ys = longint'($signed(y));
    end else begin
      xs = longint'({32'b0, x});
      ys = longint'({32'b0, y});
    end
    q = xs / ys;
    r = xs % ys;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input string nm, input logic s, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] want, input int want_lat, input bit scramble);
    int n;
    bit stall_ok;
    @(negedge clk);
    sgn = s; a = x; b = y; start = 1'b1; annul = 1'b0;
    #1 chk({nm, " stall_idle"}, stall, 1);
    @(posedge clk);
    n = 0;
    stall_ok = 1'b1;
    #1;
    while (!ready && n < 100) begin
      if (!stall) stall_ok = 1'b0;
      if (scramble) begin
        a = $urandom; b = $urandom; sgn = 1'($urandom);
      end
      @(posedge clk);
      n++;
      #1;
    end
    chk({nm, " latency"}, 64'(n + 1), 64'(want_lat));
    chk({nm, " stall_busy"}, stall_ok, 1);
    chk({nm, " result"}, result, want);
    chk({nm, " stall_end"}, stall, 0);
`ifdef DIV_ZERO_FLAG_EN
    chk({nm, " div_zero"}, dz, (y == 0));
`endif
    @(posedge clk);
    #1;
    chk({nm, " ready_hold"}, ready, 1);
    chk({nm, " result_hold"}, result, want);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, " ready_clr"}, ready, 0);
    chk({nm, " result_clr"}, result, 0);
`ifdef DIV_ZERO_FLAG_EN
    chk({nm, " div_zero_clr"}, dz, 0);
`endif
  endtask

  typedef struct {
    bit          s;
    logic [31:0] x, y, q, r;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit seen;
    int n;

    tbl[0] = '{0, 32'd100,        32'd7,          32'd14,         32'd2,          34};
    tbl[1] = '{1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   34};
    tbl[2] = '{1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          34};
    tbl[3] = '{1, 32'd5,          32'd0,          32'd0,          32'd0,          2};
    tbl[4] = '{1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          34};
    tbl[5] = '{0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          34};
    tbl[6] = '{0, 32'hFFFFFFFF,   32'h80000001,   32'd1,          32'h7FFFFFFE,   34};
    tbl[7] = '{0, 32'd3,          32'd9,          32'd0,          32'd3,          34};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("reset ready", ready, 0);
    chk("reset result", result, 0);
    chk("reset stall", stall, 0);

    foreach (tbl[i])
      run_div($sformatf("tbl%0d", i), tbl[i].s, tbl[i].x, tbl[i].y,
              {tbl[i].r, tbl[i].q}, tbl[i].lat, 1'b0);

    // annul at iteration 10 of 0xFFFFFFFF/3
    @(negedge clk);
    sgn = 1'b0; a = 32'hFFFFFFFF; b = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk) annul = 1'b1;
    #1 chk("annul stall", stall, 0);
    @(posedge clk);
    #1;
    chk("annul ready", ready, 0);
    chk("annul result", result, 0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (ready) seen = 1'b1;
    end
    chk("annul no_ready", seen, 0);
    run_div("after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 1'b0);

    // reset mid-ON
    @(negedge clk);
    sgn = 1'b0; a = 32'd1234567; b = 32'd89; start = 1'b1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_on ready", ready, 0);
    chk("rst_on result", result, 0);
    chk("rst_on stall", stall, 0);
    @(negedge clk) rst = 1'b0;
    run_div("after_rst_on", 1'b1, -32'sd100, 32'd7, ref_div(1'b1, -32'sd100, 32'd7), 34, 1'b0);

    // reset while in END with start still held
    @(negedge clk);
    sgn = 1'b0; a = 32'd1000; b = 32'd10; start = 1'b1;
    @(posedge clk);
    n = 0;
    #1;
    while (!ready && n < 100) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("rst_end reached", ready, 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_end ready", ready, 0);
    chk("rst_end result", result, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    run_div("after_rst_end", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 34, 1'b0);

    // random divides; operands scrambled while busy must be ignored
    for (int i = 0; i < 40; i++) begin
      logic        s;
      logic [31:0] x, y;
      s = 1'($urandom);
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 15);
        2:       y = -32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      run_div($sformatf("rnd%0d", i), s, x, y, ref_div(s, x, y), (y == 0) ? 2 : 34, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
